reg_file_16x16: RTL and testbench



---
 rtl/reg_file_16x16_if.sv | 31 +++
 rtl/reg_file_16x16.sv | 80 ++++++++
 tb/tb_reg_file_16x16.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/reg_file_16x16_if.sv
// reg_file_16x16_if: operand read / write-back bus of the 16x16 register file.
//   master : execute/decode side; drives indices, write enable and data.
//   slave  : register file; returns both operands and the R0-write flag.
// Signals:
//   src_reg1/src_reg2  read indices (rs, rt)
//   dst_reg, write_reg, dst_data  write-back port (rd)
//   src_data1/src_data2  read data
//   wr_r0_err  sticky flag, set when R0 was the write target
interface reg_file_16x16_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] src_reg1;
    logic [ADDR_W-1:0] src_reg2;
    logic [ADDR_W-1:0] dst_reg;
    logic              write_reg;
    logic [DATA_W-1:0] dst_data;
    logic [DATA_W-1:0] src_data1;
    logic [DATA_W-1:0] src_data2;
    logic              wr_r0_err;

    modport master (
        output src_reg1, src_reg2, dst_reg, write_reg, dst_data,
        input  src_data1, src_data2, wr_r0_err
    );

    modport slave (
        input  src_reg1, src_reg2, dst_reg, write_reg, dst_data,
        output src_data1, src_data2, wr_r0_err
    );
endinterface

// File: rtl/reg_file_16x16.sv
// reg_file_16x16: architectural register file feeding the execute stage.
// NUM_REGS x DATA_W registers, R0 hardwired to zero, two combinational read
// ports, one synchronous write port. A write aimed at R0 is dropped and
// latches wr_r0_err until reset.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears every register and the flag
//   rf     reg_file_16x16_if.slave (read indices/data, write port, flag)
// Build option:
//   REGFILE_BYPASS_EN  when defined, a same-cycle write to a read index is
//                      forwarded to that read port combinationally; otherwise
//                      reads show stored contents only.
module reg_file_16x16 #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_file_16x16_if.slave   rf
);

    generate
        if (ADDR_W != $clog2(NUM_REGS)) begin : g_bad_cfg
            $error("reg_file_16x16: ADDR_W must equal clog2(NUM_REGS)");
        end
    endgenerate

    // R0 has no storage; index 0 is decoded to zero on the read side.
    logic [DATA_W-1:0] regs [1:NUM_REGS-1];
    logic              wr_r0_err_q;

    logic wr_en;
    assign wr_en = rf.write_reg && (rf.dst_reg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++)
                if (wr_en && rf.dst_reg == ADDR_W'(i)) regs[i] <= rf.dst_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wr_r0_err_q <= 1'b0;
        else if (rf.write_reg && rf.dst_reg == '0)
            wr_r0_err_q <= 1'b1;
    end

    assign rf.wr_r0_err = wr_r0_err_q;

    // Stored-value read mux; index 0 falls through to zero.
    logic [DATA_W-1:0] rd1, rd2;
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rf.src_reg1 == ADDR_W'(i)) rd1 = regs[i];
            if (rf.src_reg2 == ADDR_W'(i)) rd2 = regs[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    // wr_en already excludes R0, so index 0 is never forwarded.
    always_comb begin
        rf.src_data1 = rd1;
        rf.src_data2 = rd2;
        if (wr_en && rf.dst_reg == rf.src_reg1) rf.src_data1 = rf.dst_data;
        if (wr_en && rf.dst_reg == rf.src_reg2) rf.src_data2 = rf.dst_data;
    end
`else
    always_comb begin
        rf.src_data1 = rd1;
        rf.src_data2 = rd2;
    end
`endif

endmodule

// File: tb/tb_reg_file_16x16.sv
module tb_reg_file_16x16;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    reg_file_16x16_if #(.DATA_W(16), .ADDR_W(4)) rf ();

    reg_file_16x16 #(.DATA_W(16), .NUM_REGS(16), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  dst;
        logic [15:0] data;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [15:0] exp1;
        logic [15:0] exp2;
        logic        exp_err;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit later, then take the rising edge.
    task automatic drive(input logic we, input logic [3:0] dst, input logic [15:0] data,
                         input logic [3:0] s1, input logic [3:0] s2);
        @(negedge clk);
        rf.write_reg = we;
        rf.dst_reg   = dst;
        rf.dst_data  = data;
        rf.src_reg1  = s1;
        rf.src_reg2  = s2;
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{1'b1, 4'd3, 16'h8009, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 4'd4, 16'h9009, 4'd3, 4'd5, 16'h8009, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 4'd0, 16'h0000, 4'd3, 4'd4, 16'h8009, 16'h9009, 1'b0};
        vecs[3] = '{1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd3, 16'h0000, 16'h8009, 1'b0};
        vecs[4] = '{1'b1, 4'd9, 16'h0FE8, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b1};
        vecs[5] = '{1'b1, 4'd1, 16'h0001, 4'd9, 4'd0, 16'h0FE8, 16'h0000, 1'b1};
        vecs[6] = '{1'b1, 4'd2, 16'h0002, 4'd1, 4'd9, 16'h0001, 16'h0FE8, 1'b1};
        vecs[7] = '{1'b0, 4'd9, 16'hABCD, 4'd9, 4'd2, 16'h0FE8, 16'h0002, 1'b1};
        vecs[8] = '{1'b0, 4'd9, 16'hABCD, 4'd9, 4'd9, 16'h0FE8, 16'h0FE8, 1'b1};
        vecs[9] = '{1'b0, 4'd0, 16'h0000, 4'd9, 4'd0, 16'h0FE8, 16'h0000, 1'b1};

        rst_n        = 1'b0;
        rf.write_reg = 1'b0;
        rf.dst_reg   = 4'd0;
        rf.dst_data  = 16'h0;
        rf.src_reg1  = 4'd5;
        rf.src_reg2  = 4'd15;
        #1;
        chk16("reset_rd1", rf.src_data1, 16'h0000);
        chk16("reset_rd2", rf.src_data2, 16'h0000);
        chk1 ("reset_err", rf.wr_r0_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read, R0 protection, sticky flag, enable gating.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].we, vecs[i].dst, vecs[i].data, vecs[i].s1, vecs[i].s2);
            chk16($sformatf("vec%0d_rd1", i), rf.src_data1, vecs[i].exp1);
            chk16($sformatf("vec%0d_rd2", i), rf.src_data2, vecs[i].exp2);
            chk1 ($sformatf("vec%0d_err", i), rf.wr_r0_err, vecs[i].exp_err);
        end

        // Same-cycle write/read hazard on R7.
        drive(1'b1, 4'd7, 16'h1111, 4'd0, 4'd0);
        drive(1'b1, 4'd7, 16'h7FFF, 4'd7, 4'd7);
`ifdef REGFILE_BYPASS_EN
        chk16("hazard_pre_rd1", rf.src_data1, 16'h7FFF);
        chk16("hazard_pre_rd2", rf.src_data2, 16'h7FFF);
`else
        chk16("hazard_pre_rd1", rf.src_data1, 16'h1111);
        chk16("hazard_pre_rd2", rf.src_data2, 16'h1111);
`endif
        drive(1'b0, 4'd7, 16'h0000, 4'd7, 4'd7);
        chk16("hazard_post_rd1", rf.src_data1, 16'h7FFF);
        chk16("hazard_post_rd2", rf.src_data2, 16'h7FFF);

        // Sweep: Rn = 0x1111*n, then read pairs (n, 16-n).
        for (int n = 1; n < 16; n++)
            drive(1'b1, 4'(n), 16'(16'h1111 * n), 4'd0, 4'd0);
        for (int n = 0; n < 16; n++) begin
            drive(1'b0, 4'd0, 16'h0, 4'(n), 4'(16 - n));
            chk16($sformatf("sweep_rd1_r%0d", n), rf.src_data1, 16'(16'h1111 * n));
            chk16($sformatf("sweep_rd2_r%0d", (16 - n) % 16), rf.src_data2,
                  16'(16'h1111 * ((16 - n) % 16)));
        end
        chk1("sweep_err_sticky", rf.wr_r0_err, 1'b1);

        // Mid-cycle asynchronous reset after loading R5.
        drive(1'b1, 4'd5, 16'h1234, 4'd0, 4'd0);
        drive(1'b0, 4'd0, 16'h0, 4'd5, 4'd7);
        chk16("preload_r5", rf.src_data1, 16'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        chk16("async_rst_r5", rf.src_data1, 16'h0000);
        chk16("async_rst_r7", rf.src_data2, 16'h0000);
        chk1 ("async_rst_err", rf.wr_r0_err, 1'b0);

        // Write presented while reset is held is lost; first write after release lands.
        drive(1'b1, 4'd6, 16'hBEEF, 4'd6, 4'd6);
        @(posedge clk);
        #1;
        chk16("rst_held_write_lost", rf.src_data1, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'd6, 16'hC0DE, 4'd0, 4'd0);
        drive(1'b0, 4'd0, 16'h0, 4'd6, 4'd5);
        chk16("first_write_after_rst", rf.src_data1, 16'hC0DE);
        chk16("r5_after_rst", rf.src_data2, 16'h0000);
        chk1 ("err_after_rst", rf.wr_r0_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
